sensor_ctrl: RTL and testbench
==============================

SENSOR_CTRL -- requirements
Module: sensor_ctrl

Interface
REQ-001 Parameter DEPTH, default 64, is the number of sample buffer entries (power of two; 6-bit index at default).
REQ-002 Parameter DATA_W, default 32, is the sample width in bits.
REQ-003 clk  input  1  clock; all state updates on the rising edge.
REQ-004 rst  input  1  reset; asynchronous, active-high.
REQ-005 sctrl_en  input  1  sampling enable from the bus wrapper, level-sensitive.
REQ-006 sctrl_clear  input  1  buffer clear from the bus wrapper, single-cycle pulse.
REQ-007 sctrl_addr  input  6  buffer read index.
REQ-008 sctrl_out  output  DATA_W  buffer contents at sctrl_addr.
REQ-009 sctrl_interrupt  output  1  buffer-full interrupt, level.
REQ-010 sensor_ready  input  1  sensor has valid data on sensor_out.
REQ-011 sensor_out  input  DATA_W  sensor sample data.
REQ-012 sensor_en  output  1  sample request to the sensor.

Function
REQ-013 The FSM SHALL have exactly three states: IDLE, REQ and FULL.
REQ-014 In IDLE: if sctrl_en=1, go to REQ next cycle; otherwise stay in IDLE.
REQ-015 sensor_en SHALL be 1 only in REQ (Moore output, no combinational path from inputs).
REQ-016 In REQ, a sample is accepted on a rising edge where sensor_en=1 and sensor_ready=1.
REQ-017 On acceptance: write sensor_out to entry count, then increment count by 1.
REQ-018 REQ transitions on acceptance:
  - count=DEPTH-1 -> FULL.
  - otherwise sctrl_en=1 -> stay in REQ (back-to-back samples, one per cycle).
  - otherwise -> IDLE.
REQ-019 In REQ with sensor_ready=0 and sctrl_en=0, go to IDLE with no write; count is retained.
REQ-020 count SHALL be a log2(DEPTH)-bit counter; it never wraps on its own; only clear or reset returns it to 0.
REQ-021 In FULL: sensor_en=0, sctrl_interrupt=1, no writes; stay until sctrl_clear.
REQ-022 sctrl_interrupt SHALL be 1 iff state=FULL.
REQ-023 sctrl_clear=1 in any state: next cycle state=IDLE, count=0, sctrl_interrupt=0.
REQ-024 sctrl_clear SHALL win over a simultaneous acceptance: that sample is discarded and not written.
REQ-025 Buffer contents SHALL NOT be changed by clear.
REQ-026 sctrl_out SHALL be a combinational read of entry sctrl_addr (zero-latency).
REQ-027 A read of the entry being written in the same cycle SHALL return the old value.
REQ-028 While sctrl_en=0, an IDLE controller SHALL stay in IDLE, including when count>0; a later sctrl_en resumes filling at count.

Reset
REQ-029 On rst: state=IDLE, count=0, sensor_en=0, sctrl_interrupt=0, all buffer entries=0.
REQ-030 rst mid-request or in FULL SHALL abort immediately, with no write on the reset edge.
REQ-031 After rst deasserts, the first request SHALL occur no earlier than the second rising edge with sctrl_en=1.

Structure
REQ-032 Package sctrl_pkg SHALL hold the state enum, DEPTH default and DATA_W default; the AHB wrapper imports it.
REQ-033 The buffer SHALL be sub-module sctrl_buf: DEPTH x DATA_W storage, one synchronous write port, one asynchronous read port, asynchronous reset to 0.
REQ-034 The FSM and counter SHALL stay in sensor_ctrl; RTL target is 120-400 lines in total.

Verification
REQ-035 Fill: rst, sctrl_en=1, sensor_ready=1, sensor_out=i+1 per cycle -> entries 0..63 = 1..64, interrupt=1 after the 64th write, sensor_en=0, no 65th write.
REQ-036 Clear in FULL: pulse sctrl_clear -> interrupt=0 next cycle, count=0; a refill writes entry 0 first, and old data at entries 1..63 is readable until overwritten.
REQ-037 Stall: sensor_ready low for 5 cycles in REQ -> sensor_en stays 1, no writes; ready=1 with sensor_out=0xA5A5_A5A5 -> entry count = 0xA5A5_A5A5.
REQ-038 Pause: sctrl_en drops after 10 samples -> IDLE, count=10; re-enable -> next sample lands in entry 10.
REQ-039 Collision: sctrl_clear and acceptance in the same cycle at count=63 -> no write, IDLE, interrupt never asserts.
REQ-040 Async reset mid-REQ at count=20 -> all outputs 0 immediately, entries read 0, sensor_en 0 until re-enabled.

Source files
------------

// File: rtl/sctrl_pkg.sv
// ============================================================================
// Module  : sctrl_pkg
// Brief   : Shared types and default sizing for the sensor controller slice.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package sctrl_pkg;

  localparam int DEPTH_DEF  = 64;
  localparam int DATA_W_DEF = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    FULL = 2'd2
  } state_t;

endpackage

`default_nettype wire

// File: rtl/sctrl_buf.sv
// ============================================================================
// Module  : sctrl_buf
// Brief   : DEPTH x DATA_W sample store, one synchronous write port and one
//           asynchronous read port, asynchronously reset to zero.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module sctrl_buf
  import sctrl_pkg::*;
#(
  parameter int DEPTH  = DEPTH_DEF,
  parameter int DATA_W = DATA_W_DEF,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [AW-1:0]     wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [AW-1:0]     rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // Read sees the pre-edge contents, so a same-cycle write returns old data.
  assign rd_data = mem[rd_addr];

endmodule

`default_nettype wire

// File: rtl/sensor_ctrl.sv
// ============================================================================
// Module  : sensor_ctrl
// Brief   : Sensor sampling FSM and fill counter feeding the sample buffer;
//           raises a level interrupt when the buffer is full.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module sensor_ctrl
  import sctrl_pkg::*;
#(
  parameter int DEPTH  = DEPTH_DEF,
  parameter int DATA_W = DATA_W_DEF,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sctrl_en,
  input  logic              sctrl_clear,
  input  logic [AW-1:0]     sctrl_addr,
  output logic [DATA_W-1:0] sctrl_out,
  output logic              sctrl_interrupt,
  input  logic              sensor_ready,
  input  logic [DATA_W-1:0] sensor_out,
  output logic              sensor_en
);

  localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

  state_t        state;
  logic [AW-1:0] count;
  logic          accept;
  logic          wr_en;

  assign accept = (state == REQ) && sensor_ready;
  // Clear beats a coincident acceptance: the sample is dropped.
  assign wr_en  = accept && !sctrl_clear;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      count <= '0;
    end else if (sctrl_clear) begin
      state <= IDLE;
      count <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (sctrl_en) begin
            state <= REQ;
          end
        end
        REQ: begin
          if (sensor_ready) begin
            // Count holds at the last index on the final write; no wrap.
            if (count == LAST) begin
              state <= FULL;
            end else begin
              count <= count + AW'(1);
              state <= sctrl_en ? REQ : IDLE;
            end
          end else if (!sctrl_en) begin
            state <= IDLE;
          end
        end
        FULL: begin
          state <= FULL;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign sensor_en       = (state == REQ);
  assign sctrl_interrupt = (state == FULL);

  sctrl_buf #(
    .DEPTH  (DEPTH),
    .DATA_W (DATA_W)
  ) u_buf (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (wr_en),
    .wr_addr (count),
    .wr_data (sensor_out),
    .rd_addr (sctrl_addr),
    .rd_data (sctrl_out)
  );

endmodule

`default_nettype wire

// File: tb/tb_sensor_ctrl.sv
// ============================================================================
// Module  : tb_sensor_ctrl
// Brief   : Randomized scoreboard bench for sensor_ctrl against a buffer model.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_sensor_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        sctrl_en = 1'b0;
  logic        sctrl_clear = 1'b0;
  logic [5:0]  sctrl_addr = '0;
  logic [31:0] sctrl_out;
  logic        sctrl_interrupt;
  logic        sensor_ready = 1'b0;
  logic [31:0] sensor_out = '0;
  logic        sensor_en;

  sensor_ctrl dut (
    .clk             (clk),
    .rst             (rst),
    .sctrl_en        (sctrl_en),
    .sctrl_clear     (sctrl_clear),
    .sctrl_addr      (sctrl_addr),
    .sctrl_out       (sctrl_out),
    .sctrl_interrupt (sctrl_interrupt),
    .sensor_ready    (sensor_ready),
    .sensor_out      (sensor_out),
    .sensor_en       (sensor_en)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        sen;
    logic        irq;
    logic [31:0] data;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  // Reference model: buffer array, fill position, requesting / full flags.
  logic [31:0] m_mem [64];
  int          m_count;
  bit          m_req;
  bit          m_full;
  bit          rst_done = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit pct(input int p);
    return $urandom_range(99, 0) < p;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 64; i++) m_mem[i] = '0;
    m_count = 0;
    m_req   = 1'b0;
    m_full  = 1'b0;
  endtask

  task automatic model_step();
    if (sctrl_clear) begin
      m_req   = 1'b0;
      m_full  = 1'b0;
      m_count = 0;
    end else if (m_req) begin
      if (sensor_ready) begin
        m_mem[m_count] = sensor_out;
        if (m_count == 63) begin
          m_full = 1'b1;
          m_req  = 1'b0;
        end else begin
          m_count = m_count + 1;
          m_req   = sctrl_en;
        end
      end else begin
        m_req = sctrl_en;
      end
    end else if (!m_full) begin
      m_req = sctrl_en;
    end
  endtask

  task automatic cycle(input int pen, input int prdy, input int pclr,
                       input bit collide, input bit rst_at20);
    exp_t e;
    @(posedge clk);
    #1;
    if (rst) rst = 1'b0;
    else     model_step();
    if (rst_at20 && !rst_done && m_req && m_count == 20) begin
      rst = 1'b1;
      #1;
      check("rst_sensor_en", {31'd0, sensor_en}, 32'd0);
      check("rst_interrupt", {31'd0, sctrl_interrupt}, 32'd0);
      check("rst_entry", sctrl_out, 32'd0);
      model_reset();
      rst_done = 1'b1;
    end
    sctrl_en     = pct(pen);
    sensor_ready = pct(prdy);
    sctrl_clear  = pct(pclr);
    sensor_out   = $urandom;
    sctrl_addr   = pct(50) ? 6'(m_count) : 6'($urandom_range(63, 0));
    if (collide && m_req && m_count == 63) begin
      sctrl_clear  = 1'b1;
      sensor_ready = 1'b1;
    end
    e.sen  = m_req;
    e.irq  = m_full;
    e.data = m_mem[sctrl_addr];
    sb.push_back(e);
  endtask

  task automatic run(input int n, input int pen, input int prdy, input int pclr,
                     input bit collide = 1'b0, input bit rst_at20 = 1'b0);
    for (int i = 0; i < n; i++) cycle(pen, prdy, pclr, collide, rst_at20);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check("sensor_en", {31'd0, sensor_en}, {31'd0, e.sen});
        check("interrupt", {31'd0, sctrl_interrupt}, {31'd0, e.irq});
        check("sctrl_out", sctrl_out, e.data);
      end
    end
  end

  initial begin : stimulus
    model_reset();
    #1;
    check("reset_sensor_en", {31'd0, sensor_en}, 32'd0);
    check("reset_interrupt", {31'd0, sctrl_interrupt}, 32'd0);
    check("reset_entry0", sctrl_out, 32'd0);
    sctrl_addr = 6'd63;
    #1;
    check("reset_entry63", sctrl_out, 32'd0);
    @(posedge clk);
    #1;
    // rst released at the start of the first modelled cycle
    run(80, 100, 100, 0);           // fill to FULL, then sit in FULL
    run(1, 100, 100, 100);          // clear pulse
    run(30, 100, 100, 0);           // refill over old contents
    run(40, 100, 30, 0);            // stalls in REQ
    run(60, 50, 60, 0);             // pause / resume
    run(1, 0, 0, 100);
    run(150, 100, 100, 0, 1'b1);    // clear collides with the 64th sample
    run(1, 0, 0, 100);
    run(40, 100, 100, 0, 1'b0, 1'b1); // async reset at count 20
    run(3000, 85, 70, 1);
    @(negedge clk);
    #1;
    check("scoreboard_drain", 32'(sb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
